// File: rtl/memory_access_stage.sv
// MEM stage: turns EX/MEM loads/stores into req/ack data-memory accesses and fills MEM/WB.
// Latency: non-memory ops 1 cycle; memory ops = ack wait cycles + 1 (aborts after TIMEOUT_CYCLES).
// Backpressure: combinational stall holds upstream from issue until the ack or timeout cycle.
module memory_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_ex_mem,
    input  logic [31:0] alu_result_ex_mem,
    input  logic [31:0] write_data_ex_mem,
    input  logic [4:0]  write_register_ex_mem,
    input  logic        ctrl_memRead_ex_mem,
    input  logic        ctrl_memWrite_ex_mem,
    input  logic        ctrl_regWrite_ex_mem,
    input  logic        ctrl_memToReg_ex_mem,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic        valid_mem_wb,
    output logic [31:0] read_data_mem_wb,
    output logic [31:0] alu_result_mem_wb,
    output logic [4:0]  write_register_mem_wb,
    output logic        ctrl_regWrite_mem_wb,
    output logic        ctrl_memToReg_mem_wb,
    output logic        misaligned_exc,
    output logic        bus_error
);

    typedef enum logic {IDLE, WAIT} state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] read_data;
        logic [31:0] alu_result;
        logic [4:0]  write_register;
        logic        reg_write;
        logic        mem_to_reg;
    } mem_wb_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state, state_nxt;
    mem_wb_t    mem_wb_q;
    logic [7:0] wait_cnt;
    logic       memop, aligned, start, timeout;
    logic       lat_load, lat_reg_write, lat_mem_to_reg;
    logic [4:0] lat_write_register;

    assign memop   = valid_ex_mem & (ctrl_memRead_ex_mem | ctrl_memWrite_ex_mem);
    assign aligned = (alu_result_ex_mem[1:0] == 2'b00);
    assign start   = (state == IDLE) & memop & aligned;
    // Ack has priority over timeout when both land in the same WAIT cycle.
    assign timeout = (state == WAIT) & ~mem_ack & (wait_cnt == TIMEOUT_LAST);
    assign mem_req = (state == WAIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = WAIT;
                    stall     = 1'b1;
                end
            end
            WAIT: begin
                if (mem_ack || timeout) state_nxt = IDLE;
                else                    stall     = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_wb_q           <= '0;
            wait_cnt           <= 8'd0;
            mem_we             <= 1'b0;
            mem_addr           <= 32'd0;
            mem_wdata          <= 32'd0;
            lat_load           <= 1'b0;
            lat_reg_write      <= 1'b0;
            lat_mem_to_reg     <= 1'b0;
            lat_write_register <= 5'd0;
            misaligned_exc     <= 1'b0;
            bus_error          <= 1'b0;
        end else begin
            misaligned_exc <= 1'b0;
            bus_error      <= 1'b0;
            case (state)
                IDLE: begin
                    wait_cnt <= 8'd0;
                    if (start) begin
                        mem_addr           <= alu_result_ex_mem;
                        mem_wdata          <= write_data_ex_mem;
                        mem_we             <= ctrl_memWrite_ex_mem;
                        lat_load           <= ctrl_memRead_ex_mem & ~ctrl_memWrite_ex_mem;
                        lat_reg_write      <= ctrl_regWrite_ex_mem;
                        lat_mem_to_reg     <= ctrl_memToReg_ex_mem;
                        lat_write_register <= write_register_ex_mem;
                        mem_wb_q           <= '0;
                    end else if (memop) begin
                        mem_wb_q       <= '0;
                        misaligned_exc <= 1'b1;
                    end else if (valid_ex_mem) begin
                        mem_wb_q.valid          <= 1'b1;
                        mem_wb_q.read_data      <= 32'd0;
                        mem_wb_q.alu_result     <= alu_result_ex_mem;
                        mem_wb_q.write_register <= write_register_ex_mem;
                        mem_wb_q.reg_write      <= ctrl_regWrite_ex_mem;
                        mem_wb_q.mem_to_reg     <= ctrl_memToReg_ex_mem;
                    end else begin
                        mem_wb_q <= '0;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        mem_wb_q.valid          <= 1'b1;
                        mem_wb_q.read_data      <= lat_load ? mem_rdata : 32'd0;
                        mem_wb_q.alu_result     <= mem_addr;
                        mem_wb_q.write_register <= lat_write_register;
                        mem_wb_q.reg_write      <= lat_reg_write;
                        mem_wb_q.mem_to_reg     <= lat_mem_to_reg;
                    end else if (timeout) begin
                        mem_wb_q  <= '0;
                        bus_error <= 1'b1;
                    end else if (wait_cnt != 8'hFF) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid_mem_wb          = mem_wb_q.valid;
    assign read_data_mem_wb      = mem_wb_q.read_data;
    assign alu_result_mem_wb     = mem_wb_q.alu_result;
    assign write_register_mem_wb = mem_wb_q.write_register;
    assign ctrl_regWrite_mem_wb  = mem_wb_q.reg_write;
    assign ctrl_memToReg_mem_wb  = mem_wb_q.mem_to_reg;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage with TIMEOUT_CYCLES=4.
module tb_memory_access_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_ex_mem = 1'b0;
    logic [31:0] alu_result_ex_mem = '0;
    logic [31:0] write_data_ex_mem = '0;
    logic [4:0]  write_register_ex_mem = '0;
    logic        ctrl_memRead_ex_mem = 1'b0;
    logic        ctrl_memWrite_ex_mem = 1'b0;
    logic        ctrl_regWrite_ex_mem = 1'b0;
    logic        ctrl_memToReg_ex_mem = 1'b0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        stall, valid_mem_wb;
    logic [31:0] read_data_mem_wb, alu_result_mem_wb;
    logic [4:0]  write_register_mem_wb;
    logic        ctrl_regWrite_mem_wb, ctrl_memToReg_mem_wb;
    logic        misaligned_exc, bus_error;

    int checks = 0;
    int errors = 0;
    int stalls;

    memory_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .valid_ex_mem          (valid_ex_mem),
        .alu_result_ex_mem     (alu_result_ex_mem),
        .write_data_ex_mem     (write_data_ex_mem),
        .write_register_ex_mem (write_register_ex_mem),
        .ctrl_memRead_ex_mem   (ctrl_memRead_ex_mem),
        .ctrl_memWrite_ex_mem  (ctrl_memWrite_ex_mem),
        .ctrl_regWrite_ex_mem  (ctrl_regWrite_ex_mem),
        .ctrl_memToReg_ex_mem  (ctrl_memToReg_ex_mem),
        .mem_req               (mem_req),
        .mem_we                (mem_we),
        .mem_addr              (mem_addr),
        .mem_wdata             (mem_wdata),
        .mem_rdata             (mem_rdata),
        .mem_ack               (mem_ack),
        .stall                 (stall),
        .valid_mem_wb          (valid_mem_wb),
        .read_data_mem_wb      (read_data_mem_wb),
        .alu_result_mem_wb     (alu_result_mem_wb),
        .write_register_mem_wb (write_register_mem_wb),
        .ctrl_regWrite_mem_wb  (ctrl_regWrite_mem_wb),
        .ctrl_memToReg_mem_wb  (ctrl_memToReg_mem_wb),
        .misaligned_exc        (misaligned_exc),
        .bus_error             (bus_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic rd, input logic wr, input logic rw,
                          input logic m2r, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] reg_no);
        valid_ex_mem          = v;
        ctrl_memRead_ex_mem   = rd;
        ctrl_memWrite_ex_mem  = wr;
        ctrl_regWrite_ex_mem  = rw;
        ctrl_memToReg_ex_mem  = m2r;
        alu_result_ex_mem     = addr;
        write_data_ex_mem     = wdata;
        write_register_ex_mem = reg_no;
    endtask

    // Cycle 0 is the issue cycle; ack is driven in cycle ack_at (-1 = never).
    // Returns at the negedge of the first non-stalled cycle.
    task automatic mem_access(input int ack_at, input logic [31:0] rdata, output int n_stall);
        n_stall = 0;
        for (int c = 0; c < 40; c++) begin
            mem_ack   = (c == ack_at);
            mem_rdata = (c == ack_at) ? rdata : 32'h0;
            @(negedge clk);
            if (!stall) break;
            n_stall++;
            tick();
        end
    endtask

    initial begin
        #1 reset = 1'b0;
        #10;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_valid", 32'(valid_mem_wb), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_exc", 32'({misaligned_exc, bus_error}), 32'd0);
        @(negedge clk) reset = 1'b1;
        tick();

        // ALU op passes through in one cycle; an ack seen in IDLE is ignored
        set_op(1, 0, 0, 1, 0, 32'h10, 32'h0, 5'd5);
        mem_ack = 1'b1;
        @(negedge clk);
        check("add_stall", 32'(stall), 32'd0);
        tick();
        mem_ack = 1'b0;
        check("add_valid", 32'(valid_mem_wb), 32'd1);
        check("add_alu", alu_result_mem_wb, 32'h10);
        check("add_reg", 32'(write_register_mem_wb), 32'd5);
        check("add_regw", 32'(ctrl_regWrite_mem_wb), 32'd1);
        check("add_rdata", read_data_mem_wb, 32'd0);
        check("add_noreq", 32'(mem_req), 32'd0);
        set_op(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        tick();
        check("bubble_valid", 32'(valid_mem_wb), 32'd0);

        // Load, ack in the fourth request cycle
        set_op(1, 1, 0, 1, 1, 32'h100, 32'h0, 5'd8);
        mem_access(4, 32'hDEAD_BEEF, stalls);
        check("lw_stalls", 32'(stalls), 32'd4);
        check("lw_req", 32'(mem_req), 32'd1);
        check("lw_addr", mem_addr, 32'h100);
        check("lw_we", 32'(mem_we), 32'd0);
        tick();
        mem_ack = 1'b0;
        set_op(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        check("lw_req_drop", 32'(mem_req), 32'd0);
        check("lw_valid", 32'(valid_mem_wb), 32'd1);
        check("lw_rdata", read_data_mem_wb, 32'hDEAD_BEEF);
        check("lw_reg", 32'(write_register_mem_wb), 32'd8);
        check("lw_m2r", 32'(ctrl_memToReg_mem_wb), 32'd1);
        check("lw_alu", alu_result_mem_wb, 32'h100);

        // Store, immediate ack
        set_op(1, 0, 1, 0, 0, 32'h204, 32'h1234_5678, 5'd0);
        mem_access(1, 32'h0, stalls);
        check("sw_stalls", 32'(stalls), 32'd1);
        check("sw_we", 32'(mem_we), 32'd1);
        check("sw_addr", mem_addr, 32'h204);
        check("sw_wdata", mem_wdata, 32'h1234_5678);
        tick();
        mem_ack = 1'b0;
        set_op(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        check("sw_valid", 32'(valid_mem_wb), 32'd1);
        check("sw_regw", 32'(ctrl_regWrite_mem_wb), 32'd0);
        check("sw_rdata", read_data_mem_wb, 32'd0);

        // Read and write both set acts as a store
        set_op(1, 1, 1, 1, 1, 32'h8, 32'hA5A5_A5A5, 5'd3);
        mem_access(1, 32'hFFFF_FFFF, stalls);
        check("both_we", 32'(mem_we), 32'd1);
        tick();
        mem_ack = 1'b0;
        set_op(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        check("both_rdata", read_data_mem_wb, 32'd0);
        check("both_valid", 32'(valid_mem_wb), 32'd1);

        // Misaligned load
        set_op(1, 1, 0, 1, 1, 32'h102, 32'h0, 5'd9);
        @(negedge clk);
        check("mis_stall", 32'(stall), 32'd0);
        tick();
        set_op(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        check("mis_exc", 32'(misaligned_exc), 32'd1);
        check("mis_valid", 32'(valid_mem_wb), 32'd0);
        check("mis_req", 32'(mem_req), 32'd0);
        tick();
        check("mis_exc_pulse", 32'(misaligned_exc), 32'd0);

        // Timeout after 4 WAIT cycles
        set_op(1, 1, 0, 1, 1, 32'h40, 32'h0, 5'd4);
        mem_access(-1, 32'h0, stalls);
        check("to_stalls", 32'(stalls), 32'd4);
        check("to_req_last", 32'(mem_req), 32'd1);
        tick();
        set_op(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        check("to_req_drop", 32'(mem_req), 32'd0);
        check("to_berr", 32'(bus_error), 32'd1);
        check("to_valid", 32'(valid_mem_wb), 32'd0);
        tick();
        check("to_berr_pulse", 32'(bus_error), 32'd0);

        // Reset during WAIT, then a clean load
        set_op(1, 1, 0, 1, 1, 32'h300, 32'h0, 5'd7);
        tick();
        check("rw_req", 32'(mem_req), 32'd1);
        set_op(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        #2 reset = 1'b0;
        #1;
        check("rw_req_drop", 32'(mem_req), 32'd0);
        check("rw_addr", mem_addr, 32'd0);
        check("rw_valid", 32'(valid_mem_wb), 32'd0);
        check("rw_exc", 32'({misaligned_exc, bus_error}), 32'd0);
        @(negedge clk) reset = 1'b1;
        tick();
        set_op(1, 1, 0, 1, 1, 32'h400, 32'h0, 5'd12);
        mem_access(2, 32'hCAFE_F00D, stalls);
        check("rl_stalls", 32'(stalls), 32'd2);
        tick();
        mem_ack = 1'b0;
        set_op(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        check("rl_rdata", read_data_mem_wb, 32'hCAFE_F00D);
        check("rl_reg", 32'(write_register_mem_wb), 32'd12);
        check("rl_valid", 32'(valid_mem_wb), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
